// File: rtl/datamem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : datamem_ctrl_if
// Purpose  : Request/response bus between a load-store unit and datamem_ctrl.
// Revision : 1.0  initial release
// ============================================================================
interface datamem_ctrl_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_size;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_size,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_size,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err
    );

endinterface : datamem_ctrl_if
`default_nettype wire

// File: rtl/datamem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : datamem_ctrl
// Purpose  : RV32 byte/half/word data memory with fixed-latency response.
// Revision : 1.0  initial release
// ============================================================================
module datamem_ctrl #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 32,   // only 32 is supported
    parameter int WAIT_STATES   = 0     // 0..7
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    datamem_ctrl_if.slave    bus
);

    localparam int         c_depth     = 2 ** ADDRESS_WIDTH;
    localparam logic [2:0] c_wait_last = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [2:0]              r_wait_cnt;
    logic [2:0]              w_wait_cnt_nxt;

    logic [DATA_WIDTH-1:0]   r_mem [c_depth];
    logic [DATA_WIDTH-1:0]   r_load_word;
    logic [2:0]              r_size;
    logic [1:0]              r_offset;
    logic                    r_we;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_legal;
    logic                    w_mem_we;
    logic [3:0]              w_be;
    logic [DATA_WIDTH-1:0]   w_wdata_rep;
    logic [ADDRESS_WIDTH-1:0] w_idx;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_load_ext;
    logic                    w_unused_addr;

    // Address bits above the word index are deliberately ignored (wrap-around).
    assign w_idx         = bus.req_addr[ADDRESS_WIDTH+1:2];
    assign w_unused_addr = ^bus.req_addr[DATA_WIDTH-1:ADDRESS_WIDTH+2];

    // Gated by rst_n so a request presented during reset can never write memory.
    assign w_accept = (r_state == S_IDLE) && bus.req_valid && rst_n;
    assign w_mem_we = w_accept && w_legal && bus.req_we;

    // ------------------------------------------------------------------------
    // Request decode: legality, byte enables and lane-replicated store data
    // ------------------------------------------------------------------------
    always_comb begin
        w_legal     = 1'b0;
        w_be        = 4'b0000;
        w_wdata_rep = '0;
        case (bus.req_size)
            c_f3_b: begin
                w_legal     = 1'b1;
                w_be        = 4'b0001 << bus.req_addr[1:0];
                w_wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            c_f3_h: begin
                w_legal     = ~bus.req_addr[0];
                w_be        = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{bus.req_wdata[15:0]}};
            end
            c_f3_w: begin
                w_legal     = (bus.req_addr[1:0] == 2'b00);
                w_be        = 4'b1111;
                w_wdata_rep = bus.req_wdata;
            end
            c_f3_bu: w_legal = ~bus.req_we;
            c_f3_hu: w_legal = ~bus.req_we & ~bus.req_addr[0];
            default: w_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Storage: not reset, so committed stores survive rst_n
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
                end
            end
        end
        if (w_accept) begin
            r_load_word <= r_mem[w_idx];
        end
    end

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 3'd0;
            r_size     <= 3'd0;
            r_offset   <= 2'd0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_accept) begin
                r_size   <= bus.req_size;
                r_offset <= bus.req_addr[1:0];
                r_we     <= bus.req_we;
                r_err    <= ~w_legal;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_wait_cnt_nxt = 3'd0;
                    w_state_nxt    = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == c_wait_last) begin
                    w_wait_cnt_nxt = 3'd0;
                    w_state_nxt    = S_RESP;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 3'd1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Load extraction from the word captured at acceptance
    // ------------------------------------------------------------------------
    always_comb begin
        case (r_offset)
            2'd0:    w_byte = r_load_word[7:0];
            2'd1:    w_byte = r_load_word[15:8];
            2'd2:    w_byte = r_load_word[23:16];
            default: w_byte = r_load_word[31:24];
        endcase
        w_half = r_offset[1] ? r_load_word[31:16] : r_load_word[15:0];
        case (r_size)
            c_f3_b:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            c_f3_bu: w_load_ext = {24'd0, w_byte};
            c_f3_h:  w_load_ext = {{16{w_half[15]}}, w_half};
            c_f3_hu: w_load_ext = {16'd0, w_half};
            c_f3_w:  w_load_ext = r_load_word;
            default: w_load_ext = '0;
        endcase
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_err   = bus.resp_valid & r_err;
    assign bus.resp_rdata = (bus.resp_valid && !r_err && !r_we) ? w_load_ext : '0;

endmodule : datamem_ctrl
`default_nettype wire

// File: doc/datamem_ctrl.md
DATAMEM_CTRL -- requirements
Module: datamem_ctrl

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 10: number of word-index bits; memory depth SHALL be 2**ADDRESS_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 32: word width; the block SHALL support only 32.
REQ-003 Parameter WAIT_STATES, default 0: extra cycles between request acceptance and response; legal range 0..7.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  3  RV32 funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-010 req_addr  input  DATA_WIDTH  byte address.
REQ-011 req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-012 resp_valid  output  1  one-cycle response strobe.
REQ-013 resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned or illegal-size request, qualified by resp_valid.

Function
REQ-015 Word index SHALL be req_addr[ADDRESS_WIDTH+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo the memory size.
REQ-016 The FSM SHALL have states IDLE, WAIT, and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request is accepted on a rising edge with req_valid=1 in IDLE; if WAIT_STATES=0 the next state SHALL be RESP, else WAIT.
REQ-018 WAIT SHALL count WAIT_STATES cycles, then go to RESP; RESP SHALL last exactly one cycle and return to IDLE.
REQ-019 resp_valid SHALL be 1 only in RESP, i.e. exactly 1+WAIT_STATES cycles after the accepting edge.
REQ-020 Back-to-back requests: minimum initiation interval SHALL be 2+WAIT_STATES cycles; req_valid held high in RESP SHALL NOT be accepted until IDLE.
REQ-021 Stores SHALL commit on the accepting edge using byte enables: SB writes byte addr[1:0]; SH writes bytes 2*addr[1]..+1; SW writes all four. Other bytes SHALL be unchanged.
REQ-022 Loads SHALL sample the word on the accepting edge and hold it in a register until RESP.
REQ-023 Load extraction: LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1]; LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word unchanged.
REQ-024 Misaligned: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL write nothing and respond with resp_err=1, resp_rdata=0.
REQ-025 Illegal req_size (011, 110, 111), or LBU/LHU codes with req_we=1, SHALL behave as misaligned (no write, resp_err=1).
REQ-026 Store responses SHALL give resp_rdata=0, resp_err=0 when legal.
REQ-027 A load following a store to the same word SHALL return the post-store data (store commits before the later acceptance edge).
REQ-028 Outputs resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.

Reset
REQ-029 While rst_n=0: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0, immediately and asynchronously.
REQ-030 Reset SHALL NOT clear memory contents; a store already committed (REQ-021) SHALL persist.
REQ-031 Reset during WAIT or RESP SHALL drop the pending response; no resp_valid for it after release.
REQ-032 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-033 WAIT_STATES=0: SW 0x8000_00F1 @0x10, then LB @0x10 -> resp_rdata=0xFFFF_FFF1; LBU @0x10 -> 0x0000_00F1; each resp_valid 1 cycle after accept.
REQ-034 SH 0xBEEF @0x22 over word 0x1122_3344 @0x20, then LW @0x20 -> 0xBEEF_3344; LH @0x22 -> 0xFFFF_BEEF; LHU @0x22 -> 0x0000_BEEF.
REQ-035 LW @0x21 and SH @0x23 -> resp_err=1, resp_rdata=0, word @0x20 unchanged; req_size=011 -> resp_err=1.
REQ-036 WAIT_STATES=3, req_valid held high: accepts at cycles 0, 5, 10; resp_valid at cycles 4, 9; req_ready=0 for cycles 1..4.
REQ-037 ADDRESS_WIDTH=10: SW 0xA5A5_A5A5 @0x1000, LW @0x0 -> 0xA5A5_A5A5 (wrap-around).
REQ-038 Assert rst_n=0 in WAIT after an accepted SW 0x1234_5678 @0x40 -> no resp_valid; after release LW @0x40 -> 0x1234_5678.
